// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: state encoding, legal prescale values and counter widths shared by the UART RX controller
package uart_rx_pkg;
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_PARITY = 3'd3;
    localparam state_t S_STOP   = 3'd4;
    localparam int PRESC_8  = 8;
    localparam int PRESC_16 = 16;
    localparam int PRESC_32 = 32;
    localparam int BIT_W    = 4;
    function automatic logic presc_ok(input logic [31:0] p);
        return p == PRESC_8 || p == PRESC_16 || p == PRESC_32;
    endfunction
endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// uart_rx_edge_bit_cnt: oversampling edge counter and data-bit counter
// CLK/RST clock and async active-low reset; en runs the edge counter (cleared when low);
// bit_en runs the bit counter (cleared when low); p is the latched prescale;
// edge_cnt/bit_cnt are the counts; bit_end flags the last edge of a bit (E == p-1).
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               en,
    input  logic               bit_en,
    input  logic [PRESC_W-1:0] p,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]   bit_cnt,
    output logic               bit_end
);
    assign bit_end = en && edge_cnt == p - PRESC_W'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            edge_cnt <= (en && !bit_end) ? edge_cnt + PRESC_W'(1) : '0;
            bit_cnt  <= !bit_en ? '0 : bit_end ? bit_cnt + BIT_W'(1) : bit_cnt;
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver frame sequencer driving sampler, deserializer and checkers
// Inputs: CLK, RST (async active-low), RX_IN serial line, prescale (8/16/32), PAR_EN,
// strt_glitch/par_err/stp_err checker results. Outputs: dat_samp_en, edge_cnt,
// deser_en/strt_chk_en/par_chk_en/stp_chk_en one-cycle strobes, data_valid/frame_err verdicts.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               PAR_EN,
    input  logic               strt_glitch,
    input  logic               par_err,
    input  logic               stp_err,
    output logic               dat_samp_en,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic               deser_en,
    output logic               strt_chk_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               data_valid,
    output logic               frame_err
);
    state_t             state, nxt;
    logic [PRESC_W-1:0] p_q;
    logic [BIT_W-1:0]   bit_cnt;
    logic               par_en_q, par_flag, bit_end, samp, start_det, last_bit;

    // prescale is only honoured at the start edge; P stays frozen for the whole frame
    assign start_det = state == S_IDLE && !RX_IN && presc_ok(32'(prescale));
    // sampler result is settled two edges before the bit ends
    assign samp      = edge_cnt == p_q - PRESC_W'(2);
    assign last_bit  = bit_cnt == BIT_W'(DATA_WIDTH - 1);

    uart_rx_edge_bit_cnt #(.PRESC_W(PRESC_W)) u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .en       (dat_samp_en),
        .bit_en   (state == S_DATA),
        .p        (p_q),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = start_det ? S_START : S_IDLE;
            S_START:  nxt = !bit_end ? S_START : strt_glitch ? S_IDLE : S_DATA;
            S_DATA:   nxt = !(bit_end && last_bit) ? S_DATA : par_en_q ? S_PARITY : S_STOP;
            S_PARITY: nxt = bit_end ? S_STOP : S_PARITY;
            S_STOP:   nxt = bit_end ? S_IDLE : S_STOP;
            default:  nxt = S_IDLE;
        endcase
    end

    always_comb begin
        dat_samp_en = state != S_IDLE;
        strt_chk_en = state == S_START && samp;
        deser_en    = state == S_DATA && samp;
        par_chk_en  = state == S_PARITY && samp;
        stp_chk_en  = state == S_STOP && samp;
    end

    // frame context and registered verdict; par_flag spans PARITY into STOP
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_q        <= '0;
            par_en_q   <= 1'b0;
            par_flag   <= 1'b0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            p_q        <= start_det ? prescale : p_q;
            par_en_q   <= (state == S_START && bit_end) ? PAR_EN : par_en_q;
            par_flag   <= start_det ? 1'b0 : (state == S_PARITY && bit_end && par_err) ? 1'b1 : par_flag;
            data_valid <= state == S_STOP && bit_end && !stp_err && !par_flag;
            frame_err  <= state == S_STOP && bit_end && (stp_err || par_flag);
        end
    end
endmodule
